// File: rtl/decode_stage_pipelined.sv
// Instruction-decode stage: register file with write-through bypass, MIPS-subset
// control decode, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipelined #(
    parameter  int DATA_WIDTH        = 32,
    parameter  int REG_COUNT         = 32,
    parameter  int STALL_COUNT_WIDTH = 16,
    localparam int REG_ADDR_WIDTH    = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ifIdValid,
    input  logic [DATA_WIDTH-1:0]        programCounterIn,
    input  logic [31:0]                  instruction,
    input  logic                         regWrite,
    input  logic [REG_ADDR_WIDTH-1:0]    writeRegister,
    input  logic [DATA_WIDTH-1:0]        writeData,
    input  logic                         idExFlush,
    output logic                         idExValid,
    output logic [1:0]                   writeBackControl,
    output logic [2:0]                   memAccessControl,
    output logic [3:0]                   calculationControl,
    output logic [DATA_WIDTH-1:0]        programCounterOut,
    output logic [DATA_WIDTH-1:0]        readData1,
    output logic [DATA_WIDTH-1:0]        readData2,
    output logic [DATA_WIDTH-1:0]        immediateOperand,
    output logic [REG_ADDR_WIDTH-1:0]    rs,
    output logic [REG_ADDR_WIDTH-1:0]    rt,
    output logic [REG_ADDR_WIDTH-1:0]    rd,
    output logic                         pcWrite,
    output logic                         ifIdWrite,
    output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [DATA_WIDTH-1:0]     regFile [REG_COUNT];
    logic [5:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rsAddr;
    logic [REG_ADDR_WIDTH-1:0] rtAddr;
    logic [REG_ADDR_WIDTH-1:0] rdAddr;
    logic signed [15:0]        immRaw;
    logic [DATA_WIDTH-1:0]     immExtended;
    logic [DATA_WIDTH-1:0]     readValue1;
    logic [DATA_WIDTH-1:0]     readValue2;
    logic [8:0]                controlNext;
    logic                      hazard;
    logic                      loadBubble;
    logic                      unusedInstructionBits;

    // Register fields are truncated to the configured address width, so the
    // upper address bits are intentionally dropped when REG_COUNT < 32.
    assign opcode                = instruction[31:26];
    assign rsAddr                = instruction[21 +: REG_ADDR_WIDTH];
    assign rtAddr                = instruction[16 +: REG_ADDR_WIDTH];
    assign rdAddr                = instruction[11 +: REG_ADDR_WIDTH];
    assign immRaw                = instruction[15:0];
    assign immExtended           = DATA_WIDTH'(immRaw);
    assign unusedInstructionBits = ^instruction;

    // Register file write port; register 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else if (regWrite && (writeRegister != '0)) begin
            regFile[writeRegister] <= writeData;
        end
    end

    // Operand reads: r0 reads as zero, and a same-cycle write-back is forwarded.
    always_comb begin
        readValue1 = '0;
        readValue2 = '0;
        if (rsAddr != '0) begin
            if (regWrite && (writeRegister == rsAddr)) begin
                readValue1 = writeData;
            end else begin
                readValue1 = regFile[rsAddr];
            end
        end
        if (rtAddr != '0) begin
            if (regWrite && (writeRegister == rtAddr)) begin
                readValue2 = writeData;
            end else begin
                readValue2 = regFile[rtAddr];
            end
        end
    end

    // Opcode decode into {wb[1:0], mem[2:0], calc[3:0]}; unknown opcodes get no control.
    always_comb begin
        controlNext = '0;
        case (opcode)
            OP_RTYPE: controlNext = 9'b10_000_1010;
            OP_LW:    controlNext = 9'b11_010_0100;
            OP_SW:    controlNext = 9'b00_001_0100;
            OP_BEQ:   controlNext = 9'b00_100_0001;
            OP_ADDI:  controlNext = 9'b10_000_0100;
            default:  controlNext = '0;
        endcase
    end

    // Load-use hazard: the load in ID/EX targets a register this instruction reads.
    always_comb begin
        hazard = idExValid && memAccessControl[1] && (rt != '0) && ifIdValid &&
                 ((rt == rsAddr) || (rt == rtAddr));
        loadBubble = idExFlush || hazard || !ifIdValid;
        pcWrite    = !hazard;
        ifIdWrite  = !hazard;
    end

    // ID/EX pipeline register; a bubble only clears validity and control, data still loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            idExValid          <= 1'b0;
            writeBackControl   <= '0;
            memAccessControl   <= '0;
            calculationControl <= '0;
            programCounterOut  <= '0;
            readData1          <= '0;
            readData2          <= '0;
            immediateOperand   <= '0;
            rs                 <= '0;
            rt                 <= '0;
            rd                 <= '0;
        end else begin
            idExValid          <= !loadBubble;
            writeBackControl   <= loadBubble ? 2'b00   : controlNext[8:7];
            memAccessControl   <= loadBubble ? 3'b000  : controlNext[6:4];
            calculationControl <= loadBubble ? 4'b0000 : controlNext[3:0];
            programCounterOut  <= programCounterIn;
            readData1          <= readValue1;
            readData2          <= readValue2;
            immediateOperand   <= immExtended;
            rs                 <= rsAddr;
            rt                 <= rtAddr;
            rd                 <= rdAddr;
        end
    end

    // Saturating count of hazard stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (hazard && (stallCount != {STALL_COUNT_WIDTH{1'b1}})) begin
            stallCount <= stallCount + STALL_COUNT_WIDTH'(1);
        end
    end

endmodule
